// File: rtl/prefetch_fetch_unit.sv
// Prefetching instruction fetch stage: credit-limited valid/ready fetch into a
// small FIFO, with redirect flush and discard of responses already in flight.
module prefetch_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          imem_req_valid,
  output logic [XLEN-1:0]               imem_req_addr,
  input  logic                          imem_req_ready,
  input  logic                          imem_rsp_valid,
  input  logic [31:0]                   imem_rsp_data,
  input  logic                          branch_taken,
  input  logic [XLEN-1:0]               branch_target,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [31:0]                   instruction,
  output logic [XLEN-1:0]               pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   outs_q, outs_d;
  logic [CW-1:0]   disc_q, disc_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;

  logic [31:0]     data_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pcs_mem  [FIFO_DEPTH];

  logic            req_fire, pop, rsp_live, rsp_drop, push, pop_eff;
  logic            room_ok, credit_ok;
  logic [XLEN-1:0] target;
  logic            unused_tgt_bits;

  assign target          = {branch_target[XLEN-1:2], 2'b00};
  assign unused_tgt_bits = ^branch_target[1:0];

  // Request only when every in-flight response is guaranteed a FIFO slot
  // and the discard counter cannot overflow.
  assign room_ok        = ({1'b0, cnt_q} + {1'b0, outs_q}) < DEPTH_X;
  assign credit_ok      = ({1'b0, outs_q} + {1'b0, disc_q}) < DEPTH_X;
  assign imem_req_valid = !reset && !branch_taken && room_ok && credit_ok;
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign inst_valid = (cnt_q != '0);
  assign pop      = inst_valid & inst_ready;
  assign rsp_live = imem_rsp_valid & (disc_q == '0);
  assign rsp_drop = imem_rsp_valid & (disc_q != '0);
  assign push     = rsp_live & !branch_taken;
  assign pop_eff  = pop & !branch_taken;

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign fifo_count  = cnt_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    cnt_d      = cnt_q;
    outs_d     = outs_q + CW'(req_fire) - CW'(rsp_live);
    disc_d     = disc_q - CW'(rsp_drop);
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    if (branch_taken) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      cnt_d      = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      disc_d     = disc_q - CW'(rsp_drop) + outs_q - CW'(rsp_live);
      outs_d     = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
        wptr_d   = wptr_q + PW'(1);
      end
      rptr_d = rptr_q + PW'(pop_eff);
      cnt_d  = cnt_q + CW'(push) - CW'(pop_eff);
      // Head register follows the new read slot; an entry written this
      // cycle into an otherwise empty FIFO comes straight from the response.
      if (cnt_d != '0) begin
        if (push && ((cnt_q - CW'(pop_eff)) == '0)) begin
          instr_d = imem_rsp_data;
          pc_d    = rsp_pc_q;
        end else begin
          instr_d = data_mem[rptr_d];
          pc_d    = pcs_mem[rptr_d];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      cnt_q      <= '0;
      outs_q     <= '0;
      disc_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      instr_q    <= '0;
      pc_q       <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      cnt_q      <= cnt_d;
      outs_q     <= outs_d;
      disc_q     <= disc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wptr_q] <= imem_rsp_data;
      pcs_mem[wptr_q]  <= rsp_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(rsp_live && (cnt_q == DEPTH_C)));
  end

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Directed bench for prefetch_fetch_unit with a fixed-latency in-order memory.
module tb_prefetch_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  typedef struct {int due; logic [31:0] addr;} pend_t;
  pend_t       pend[$];
  logic [31:0] req_log[$];

  prefetch_fetch_unit #(.XLEN(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .pc(pc), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  // Memory: accept at the edge, answer in order lat cycles later.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) pend.delete();
      else if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{due: cyc + lat - 1, addr: imem_req_addr});
        req_log.push_back(imem_req_addr);
      end
      #1;
      if (reset) begin
        pend.delete();
        imem_rsp_valid = 1'b0;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    branch_taken = 1'b0;
    repeat (2) tick();
    req_log.delete();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_instr", instruction, 0);
    check("rst_pc", pc, 0);
    check("rst_count", fifo_count, 0);

    // 1: streaming, 1-cycle memory, decoder always ready
    lat = 1; inst_ready = 1; imem_req_ready = 1;
    do_reset();
    check("t1_req0_valid", imem_req_valid, 1);
    check("t1_req0_addr", imem_req_addr, 32'h0);
    tick();
    check("t1_iv_early", inst_valid, 0);
    check("t1_req1_addr", imem_req_addr, 32'h4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_iv", inst_valid, 1);
      check("t1_pc", pc, 32'(4 * k));
      check("t1_instr", instruction, mem_word(32'(4 * k)));
      check("t1_req_addr", imem_req_addr, 32'(4 * k + 8));
    end

    // 2: decoder stalled, FIFO fills, single pop frees one credit
    inst_ready = 0;
    do_reset();
    repeat (8) tick();
    check("t2_nreq", req_log.size(), 4);
    check("t2_last_req", req_log[3], 32'hC);
    check("t2_count", fifo_count, 4);
    check("t2_req_valid", imem_req_valid, 0);
    check("t2_pc", pc, 32'h0);
    inst_ready = 1;
    tick();
    inst_ready = 0;
    #1;
    check("t2_req_after_pop", imem_req_valid, 1);
    check("t2_addr_after_pop", imem_req_addr, 32'h10);
    repeat (3) tick();
    check("t2_nreq2", req_log.size(), 5);
    check("t2_req10", req_log[4], 32'h10);
    check("t2_count2", fifo_count, 4);
    check("t2_pc2", pc, 32'h4);
    check("t2_instr2", instruction, 32'hA000_0004);
    check("t2_req_valid2", imem_req_valid, 0);

    // 3: 3-cycle memory, redirect with two requests in flight
    lat = 3; inst_ready = 0; imem_req_ready = 1;
    do_reset();
    tick();
    tick();
    imem_req_ready = 0;
    tick();
    tick();
    tick();
    check("t3_count_pre", fifo_count, 2);
    imem_req_ready = 1;
    tick();
    tick();
    imem_req_ready = 0;
    branch_taken = 1; branch_target = 32'h100;
    #1;
    check("t3_nreq", req_log.size(), 4);
    check("t3_count_prebr", fifo_count, 2);
    tick();
    branch_taken = 0; imem_req_ready = 1;
    #1;
    check("t3_count_flush", fifo_count, 0);
    check("t3_iv_flush", inst_valid, 0);
    check("t3_req_valid", imem_req_valid, 1);
    check("t3_req_addr", imem_req_addr, 32'h100);
    for (int i = 0; i < 8 && !inst_valid; i++) tick();
    check("t3_deliv", inst_valid, 1);
    check("t3_pc", pc, 32'h100);
    check("t3_instr", instruction, 32'hA000_0100);
    check("t3_count1", fifo_count, 1);

    // 4: misaligned redirect with simultaneous pop and response
    lat = 1; inst_ready = 1; imem_req_ready = 1;
    do_reset();
    tick();
    tick();
    check("t4_iv_pre", inst_valid, 1);
    branch_taken = 1; branch_target = 32'h203;
    #1;
    check("t4_req_blocked", imem_req_valid, 0);
    tick();
    branch_taken = 0;
    #1;
    check("t4_count", fifo_count, 0);
    check("t4_req_addr", imem_req_addr, 32'h200);
    check("t4_req_valid", imem_req_valid, 1);
    tick();
    tick();
    check("t4_iv", inst_valid, 1);
    check("t4_pc", pc, 32'h200);
    check("t4_instr", instruction, 32'hA000_0200);

    // 5: memory not ready for 5 cycles
    lat = 1; inst_ready = 1; imem_req_ready = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      check("t5_valid_hold", imem_req_valid, 1);
      check("t5_addr_hold", imem_req_addr, 32'h0);
      tick();
    end
    imem_req_ready = 1;
    tick();
    check("t5_addr_adv", imem_req_addr, 32'h4);
    check("t5_nreq", req_log.size(), 1);

    // 6: asynchronous reset with three entries buffered
    lat = 1; inst_ready = 0; imem_req_ready = 1;
    do_reset();
    repeat (4) tick();
    check("t6_count_pre", fifo_count, 3);
    reset = 1;
    #1;
    check("t6_count_rst", fifo_count, 0);
    check("t6_iv_rst", inst_valid, 0);
    check("t6_req_rst", imem_req_valid, 0);
    check("t6_pc_rst", pc, 32'h0);
    check("t6_instr_rst", instruction, 32'h0);
    do_reset();
    check("t6_req_addr", imem_req_addr, 32'h0);
    check("t6_req_valid", imem_req_valid, 1);
    tick();
    tick();
    check("t6_iv", inst_valid, 1);
    check("t6_pc", pc, 32'h0);
    check("t6_instr", instruction, 32'hA000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prefetch_fetch_unit.md
Name: prefetch_fetch_unit

Overview:
Parametrised successor to the core's single-cycle instruction fetch path. It decouples fetch from decode with a prefetch FIFO and a valid/ready instruction memory interface that tolerates variable memory latency. It handles branch redirects by flushing the FIFO and discarding in-flight responses. It sits between instruction memory and the decoder in the next-generation riscv_processor.

Parameters:
XLEN, 32, address/PC width in bits.
FIFO_DEPTH, 4, prefetch entries; power of two, >=2; also the maximum number of in-flight requests.
RESET_PC, 0, fetch address after reset; must be 4-byte aligned.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
imem_req_valid  output  1  fetch request valid.
imem_req_addr  output  XLEN  fetch byte address, always 4-aligned.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_rsp_valid  input  1  in-order response valid; no backpressure.
imem_rsp_data  input  32  response instruction word.
branch_taken  input  1  redirect strobe from execute.
branch_target  input  XLEN  redirect address; bits [1:0] are ignored and treated as 0.
inst_valid  output  1  FIFO head holds a valid instruction.
inst_ready  input  1  decoder consumes the head.
instruction  output  32  FIFO head instruction word.
pc  output  XLEN  PC of the FIFO head.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async): fetch_pc=RESET_PC, rsp_pc=RESET_PC, fifo_count=0, outstanding=0, discard=0, imem_req_valid=0, inst_valid=0, instruction=0, pc=RESET_PC. Instruction memory shares this reset; no pre-reset response arrives after reset.
- Defined events: req_fire = imem_req_valid & imem_req_ready; pop = inst_valid & inst_ready; rsp_live = imem_rsp_valid & (discard==0).
- Request rule: imem_req_valid = !branch_taken & (fifo_count+outstanding < FIFO_DEPTH) & (outstanding+discard < FIFO_DEPTH). imem_req_addr = fetch_pc.
- Stability: once asserted, imem_req_valid and imem_req_addr stay stable until req_fire. The only exception is a redirect, which may withdraw the request.
- On req_fire without redirect: fetch_pc += 4, wrapping modulo 2^XLEN.
- Response with discard>0: the data is dropped and discard decrements.
- Response with discard==0 (rsp_live): push {rsp_pc, imem_rsp_data} into the FIFO, then rsp_pc += 4 and outstanding decrements.
- Credit guarantee: the request rule guarantees FIFO space for every live response, so overflow is impossible. An assertion fires if rsp_live arrives with fifo_count==FIFO_DEPTH.
- outstanding update: outstanding_next = outstanding + req_fire - rsp_live.
- Redirect (branch_taken=1) has priority over everything else in that cycle:
  - FIFO cleared (fifo_count=0, pointers reset); any pop that cycle is ignored.
  - No request issues that cycle.
  - fetch_pc and rsp_pc are set to {branch_target[XLEN-1:2],2'b00}.
  - discard_next = discard + outstanding - rsp_live, and outstanding_next = 0.
  - A response arriving in the redirect cycle counts toward discard/live exactly as above, but its data is never stored.
- FIFO: circular buffer with read/write pointers of width $clog2(FIFO_DEPTH), wrapping naturally.
  - Simultaneous push and pop leaves the count unchanged and is legal when full (pop frees the slot).
  - No bypass: a response is visible on inst_valid/instruction/pc one cycle after imem_rsp_valid.
- inst_valid = (fifo_count != 0). instruction and pc are registered FIFO head outputs. Their values are don't-care when inst_valid=0, but they must hold stable while inst_valid=1 and inst_ready=0.
- Back-to-back throughput: one instruction per cycle when memory has single-cycle latency and the decoder is always ready.

Test Plan:
- Reset release, memory with 1-cycle latency, inst_ready=1: request addresses 0x0, 0x4, 0x8, … on consecutive cycles; inst_valid rises two cycles after the first req_fire; pc sequence 0x0, 0x4, 0x8 with matching instruction words.
- inst_ready=0 with memory always ready: exactly 4 requests issue (0x0–0xC); fifo_count settles at 4; imem_req_valid stays 0. Raising inst_ready for one cycle yields exactly one new request, to 0x10.
- Memory latency 3 cycles, redirect to 0x100 issued while 2 requests are outstanding: FIFO empties the next cycle; the next 2 responses are dropped; the first delivered instruction has pc=0x100.
- branch_target=0x203 with a simultaneous pop and response: target is treated as 0x200; fifo_count becomes 0; the next request address is 0x200; the response arriving in that cycle is discarded.
- imem_req_ready held low for 5 cycles: imem_req_addr stays 0x0 with valid high throughout; fetch_pc advances only after ready rises.
- Async reset asserted mid-stream with FIFO holding 3 entries: outputs immediately take their reset values; after release, fetching restarts at RESET_PC.
